// File: rtl/regfile_pkg.sv
// Shared types and helpers for the multi-port register file.
// Optional build macro used by regfile_mp: REGFILE_BYPASS_EN.
package regfile_pkg;

  localparam int WIDTH_DEF = 32;
  localparam int DEPTH_DEF = 32;

  typedef enum logic {
    ST_IDLE  = 1'b0,
    ST_CLEAR = 1'b1
  } clr_state_t;

  function automatic int addr_w(input int depth);
    return (depth <= 2) ? 1 : $clog2(depth);
  endfunction

endpackage

// File: rtl/regfile_clear_seq.sv
// Clear-sweep sequencer: walks every register address once, one per cycle,
// and flags the file busy while the sweep runs.
//
// state    | meaning
// ---------+-------------------------------------------------------------
// ST_IDLE  | normal operation; a clear_req pulse starts a sweep at addr 0
// ST_CLEAR | zeroing register clr_addr this cycle; exits after DEPTH-1
module regfile_clear_seq
  import regfile_pkg::*;
#(
  parameter int DEPTH = DEPTH_DEF,
  parameter int AW    = addr_w(DEPTH)
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          clear_req,
  output logic          busy,
  output logic          clr_en,
  output logic [AW-1:0] clr_addr
);

  clr_state_t    state, state_nxt;
  logic [AW-1:0] cnt, cnt_nxt;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= ST_IDLE;
      cnt   <= '0;
    end else begin
      state <= state_nxt;
      cnt   <= cnt_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    cnt_nxt   = cnt;
    case (state)
      ST_IDLE: begin
        if (clear_req) begin
          state_nxt = ST_CLEAR;
          cnt_nxt   = '0;
        end
      end
      ST_CLEAR: begin
        cnt_nxt = cnt + 1'b1;
        if (cnt == AW'(DEPTH - 1)) state_nxt = ST_IDLE;
      end
      default: state_nxt = ST_IDLE;
    endcase
  end

  assign busy     = (state == ST_CLEAR);
  assign clr_en   = (state == ST_CLEAR);
  assign clr_addr = cnt;

endmodule

// File: rtl/regfile_mp.sv
// Parametrised multi-port register file with async reset and sweep clear.
// Define REGFILE_BYPASS_EN to forward same-cycle write data onto read ports.
module regfile_mp
  import regfile_pkg::*;
#(
  parameter  int WIDTH    = WIDTH_DEF,
  parameter  int DEPTH    = DEPTH_DEF,
  parameter  int NREAD    = 2,
  parameter  int NWRITE   = 1,
  parameter  int ZERO_REG = 1,
  localparam int AW       = addr_w(DEPTH)
) (
  input  logic                    Clk,
  input  logic                    ResetN,
  input  logic [NREAD*AW-1:0]     ReadRegister,
  output logic [NREAD*WIDTH-1:0]  ReadData,
  input  logic [NWRITE*AW-1:0]    WriteRegister,
  input  logic [NWRITE*WIDTH-1:0] WriteData,
  input  logic [NWRITE-1:0]       RegWrite,
  input  logic                    ClearReq,
  output logic                    Busy
);

  logic [WIDTH-1:0]            mem [DEPTH];
  logic [NREAD-1:0][WIDTH-1:0] rd;
  logic                        clr_en;
  logic [AW-1:0]               clr_addr;

  regfile_clear_seq #(.DEPTH(DEPTH), .AW(AW)) u_clear_seq (
    .clk       (Clk),
    .rst_n     (ResetN),
    .clear_req (ClearReq),
    .busy      (Busy),
    .clr_en    (clr_en),
    .clr_addr  (clr_addr)
  );

  // Later ports overwrite earlier ones in the loop, so the highest port wins.
  always_ff @(posedge Clk or negedge ResetN) begin
    if (!ResetN) begin
      for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
    end else if (clr_en) begin
      mem[clr_addr] <= '0;
    end else if (!ClearReq) begin
      for (int w = 0; w < NWRITE; w++) begin
        if (RegWrite[w] && !(ZERO_REG != 0 && WriteRegister[w*AW +: AW] == '0))
          mem[WriteRegister[w*AW +: AW]] <= WriteData[w*WIDTH +: WIDTH];
      end
    end
  end

  always_comb begin
    for (int r = 0; r < NREAD; r++) begin
      rd[r] = mem[ReadRegister[r*AW +: AW]];
`ifdef REGFILE_BYPASS_EN
      if (!Busy) begin
        for (int w = 0; w < NWRITE; w++) begin
          if (RegWrite[w] && WriteRegister[w*AW +: AW] == ReadRegister[r*AW +: AW])
            rd[r] = WriteData[w*WIDTH +: WIDTH];
        end
      end
`endif
      if (ZERO_REG != 0 && ReadRegister[r*AW +: AW] == '0) rd[r] = '0;
    end
  end

  assign ReadData = rd;

endmodule

// File: tb/tb_regfile_mp.sv
// Scoreboard bench for regfile_mp (32x32, 2 read ports, 2 write ports).
module tb_regfile_mp;

  logic        Clk = 1'b0;
  logic        ResetN;
  logic [9:0]  ReadRegister;
  logic [63:0] ReadData;
  logic [9:0]  WriteRegister;
  logic [63:0] WriteData;
  logic [1:0]  RegWrite;
  logic        ClearReq;
  logic        Busy;

  int          n_checks = 0;
  int          n_pass   = 0;
  logic [31:0] model [32];
  logic [31:0] sb_q [$];

  always #5 Clk = ~Clk;

  regfile_mp #(.WIDTH(32), .DEPTH(32), .NREAD(2), .NWRITE(2), .ZERO_REG(1)) dut (
    .Clk           (Clk),
    .ResetN        (ResetN),
    .ReadRegister  (ReadRegister),
    .ReadData      (ReadData),
    .WriteRegister (WriteRegister),
    .WriteData     (WriteData),
    .RegWrite      (RegWrite),
    .ClearReq      (ClearReq),
    .Busy          (Busy)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
  endtask

  function automatic logic [31:0] mval(input logic [4:0] a);
    return (a == 5'd0) ? 32'd0 : model[a];
  endfunction

  task automatic read_pair(input logic [4:0] a0, input logic [4:0] a1, input string tag);
    ReadRegister = {a1, a0};
    sb_q.push_back(mval(a0));
    sb_q.push_back(mval(a1));
    #1;
    chk($sformatf("%s.p0[%0d]", tag, a0), ReadData[31:0], sb_q.pop_front());
    chk($sformatf("%s.p1[%0d]", tag, a1), ReadData[63:32], sb_q.pop_front());
  endtask

  task automatic write_cycle(input logic we0, input logic [4:0] a0, input logic [31:0] d0,
                             input logic we1, input logic [4:0] a1, input logic [31:0] d1);
    RegWrite      = {we1, we0};
    WriteRegister = {a1, a0};
    WriteData     = {d1, d0};
    @(posedge Clk);
    if (we0 && a0 != 5'd0) model[a0] = d0;
    if (we1 && a1 != 5'd0) model[a1] = d1;
    #1;
    RegWrite = 2'b00;
  endtask

  task automatic clear_model();
    for (int i = 0; i < 32; i++) model[i] = 32'd0;
  endtask

  initial begin
    int n;
    logic [31:0] old6;
    clear_model();
    ResetN = 1'b0; ReadRegister = '0; WriteRegister = '0; WriteData = '0;
    RegWrite = '0; ClearReq = 1'b0;
    #12;
    chk("reset_busy", {31'd0, Busy}, 32'd0);
    read_pair(5'd2, 5'd31, "reset");
    ResetN = 1'b1;
    @(posedge Clk); #1;

    // back-to-back writes to one register
    write_cycle(1'b1, 5'd2, 32'd42, 1'b0, 5'd0, 32'd0);
    read_pair(5'd2, 5'd2, "w42");
    write_cycle(1'b1, 5'd2, 32'd15, 1'b0, 5'd0, 32'd0);
    read_pair(5'd2, 5'd2, "w15");

    // register 0 and disabled write
    write_cycle(1'b1, 5'd0, 32'd25, 1'b0, 5'd0, 32'd0);
    read_pair(5'd0, 5'd0, "zero");
    write_cycle(1'b0, 5'd3, 32'd34, 1'b0, 5'd0, 32'd0);
    read_pair(5'd3, 5'd0, "nowe");

    write_cycle(1'b1, 5'd1, 32'd1, 1'b0, 5'd0, 32'd0);
    write_cycle(1'b1, 5'd4, 32'd9, 1'b0, 5'd0, 32'd0);
    read_pair(5'd1, 5'd4, "r1r4");

    // aliasing sweep using both write ports
    for (int a = 0; a < 32; a += 2)
      write_cycle(1'b1, 5'(a), 32'(a * 3), 1'b1, 5'(a + 1), 32'((a + 1) * 3));
    for (int a = 0; a < 32; a += 2) read_pair(5'(a), 5'(a + 1), "alias");

    // same-address write priority
    write_cycle(1'b1, 5'd5, 32'hAAAA, 1'b1, 5'd5, 32'h5555);
    read_pair(5'd5, 5'd5, "prio");

    // same-cycle visibility of a write
    old6 = mval(5'd6);
    RegWrite = 2'b01; WriteRegister = {5'd0, 5'd6}; WriteData = {32'd0, 32'h1234};
    ReadRegister = {5'd6, 5'd6};
`ifdef REGFILE_BYPASS_EN
    sb_q.push_back(32'h1234);
`else
    sb_q.push_back(old6);
`endif
    #1;
    chk("bypass_pre", ReadData[31:0], sb_q.pop_front());
    @(posedge Clk); model[6] = 32'h1234; #1;
    RegWrite = 2'b00;
    read_pair(5'd6, 5'd6, "bypass_post");

    // fill, then sweep clear; write alongside ClearReq is dropped
    for (int a = 1; a < 32; a++) write_cycle(1'b1, 5'(a), 32'(a + 100), 1'b0, 5'd0, 32'd0);
    ClearReq = 1'b1;
    RegWrite = 2'b01; WriteRegister = {5'd0, 5'd31}; WriteData = {32'd0, 32'hDEAD};
    @(posedge Clk); #1;
    ClearReq = 1'b0; RegWrite = 2'b00;
    chk("clr_busy_rise", {31'd0, Busy}, 32'd1);
    read_pair(5'd0, 5'd31, "clr_drop_start");
    n = 0;
    while (Busy && n < 100) begin
      n++;
      if (n == 3) begin
        ReadRegister = {5'd31, 5'd1};
        sb_q.push_back(32'd0);
        sb_q.push_back(32'd131);
        #1;
        chk("mid_cleared", ReadData[31:0], sb_q.pop_front());
        chk("mid_pending", ReadData[63:32], sb_q.pop_front());
      end
      if (n == 20) begin
        RegWrite = 2'b01; WriteRegister = {5'd0, 5'd9}; WriteData = {32'd0, 32'd7};
        ClearReq = 1'b1;
      end
      @(posedge Clk); #1;
      RegWrite = 2'b00; ClearReq = 1'b0;
    end
    chk("busy_cycles", 32'(n), 32'd32);
    clear_model();
    for (int a = 0; a < 32; a += 2) read_pair(5'(a), 5'(a + 1), "after_clr");

    // reset mid-sweep
    for (int a = 1; a < 8; a++) write_cycle(1'b1, 5'(a), 32'(a + 200), 1'b0, 5'd0, 32'd0);
    ClearReq = 1'b1;
    @(posedge Clk); #1;
    ClearReq = 1'b0;
    repeat (3) @(posedge Clk);
    #2;
    ResetN = 1'b0;
    #1;
    chk("rst_mid_busy", {31'd0, Busy}, 32'd0);
    clear_model();
    for (int a = 0; a < 8; a += 2) read_pair(5'(a), 5'(a + 1), "rst_mid");
    ResetN = 1'b1;
    @(posedge Clk); #1;
    write_cycle(1'b1, 5'd7, 32'd77, 1'b0, 5'd0, 32'd0);
    read_pair(5'd7, 5'd6, "post_rst");

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
